// File: rtl/ifetch_queue_pkg.sv
// Shared types for the instruction prefetch queue: ibus request/response, queue entry, FSM state.
// Consumed by ifetch_queue and ifetch_queue_fifo.
package ifetch_queue_pkg;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

    typedef struct packed {
        logic [63:0] addr;
        logic [31:0] data;
    } fq_entry_t;

    typedef enum logic [1:0] {
        FQ_IDLE = 2'd0,
        FQ_REQ  = 2'd1,
        FQ_WAIT = 2'd2
    } fq_state_t;

    localparam logic [63:0] FQ_ADDR_STEP = 64'd4;

endpackage

// File: rtl/ifetch_queue_fifo.sv
// Ring buffer of prefetched {addr, data} entries with push/pop/flush; flush dominates push.
// The caller guarantees no push when full (unless popping) and no pop when empty.
module ifetch_queue_fifo
    import ifetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   push_i,
    input  fq_entry_t              push_entry_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    output fq_entry_t              head_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    fq_entry_t     mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push_i && !pop_i)      count_d = count_q + 1'b1;
            else if (pop_i && !push_i) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only observed while count_q says they are valid.
    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_entry_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/ifetch_queue.sv
// Sequential instruction prefetch queue between the core fetch port and the ibus.
// Optional macro IFETCH_QUEUE_BYPASS_EN forwards a matching in-flight word straight to the core.
module ifetch_queue
    import ifetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  ibus_req_t  creq,
    output ibus_resp_t cresp,
    output ibus_req_t  ireq,
    input  ibus_resp_t iresp
);

    localparam int unsigned   CW   = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    fq_state_t     state_q, state_d;
    logic          stale_q, stale_d;
    logic          armed_q, armed_d;
    logic [63:0]   nxt_addr_q, nxt_addr_d;
    logic [63:0]   inflight_q, inflight_d;

    fq_entry_t     head;
    fq_entry_t     push_entry;
    logic [CW-1:0] count;
    logic          busy, resolve, hit, pending, miss, bypass, push;

    assign busy    = (state_q != FQ_IDLE);
    assign resolve = ((state_q == FQ_REQ) && iresp.addr_ok && iresp.data_ok)
                  || ((state_q == FQ_WAIT) && iresp.data_ok);
    assign hit     = creq.valid && (count != '0) && (head.addr == creq.addr);
    assign pending = creq.valid && !hit && (count == '0) && busy && !stale_q
                  && (inflight_q == creq.addr);
    assign miss    = creq.valid && !hit && !pending;

`ifdef IFETCH_QUEUE_BYPASS_EN
    assign bypass  = pending && resolve;
`else
    assign bypass  = 1'b0;
`endif

    assign push       = resolve && !stale_q && !bypass;
    assign push_entry = '{addr: inflight_q, data: iresp.data};

    ifetch_queue_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i        (clk),
        .reset_i      (reset),
        .push_i       (push),
        .push_entry_i (push_entry),
        .pop_i        (hit),
        .flush_i      (miss),
        .head_o       (head),
        .count_o      (count)
    );

    always_comb begin
        cresp = '0;
        if (hit) begin
            cresp.addr_ok = 1'b1;
            cresp.data_ok = 1'b1;
            cresp.data    = head.data;
        end else if (bypass) begin
            cresp.addr_ok = 1'b1;
            cresp.data_ok = 1'b1;
            cresp.data    = iresp.data;
        end
    end

    assign ireq.valid = (state_q == FQ_REQ);
    assign ireq.addr  = (state_q == FQ_REQ) ? inflight_q : '0;

    always_comb begin
        state_d    = state_q;
        stale_d    = stale_q;
        armed_d    = armed_q | creq.valid;
        nxt_addr_d = nxt_addr_q;
        inflight_d = inflight_q;
        unique case (state_q)
            // A miss seen in IDLE issues the missed address directly, so the
            // request never carries the pre-flush sequential address.
            FQ_IDLE: begin
                if (miss || (armed_q && (count < FULL))) begin
                    state_d    = FQ_REQ;
                    inflight_d = miss ? creq.addr : nxt_addr_q;
                end
            end
            FQ_REQ: begin
                if (iresp.addr_ok) begin
                    nxt_addr_d = nxt_addr_q + FQ_ADDR_STEP;
                    state_d    = iresp.data_ok ? FQ_IDLE : FQ_WAIT;
                end
            end
            FQ_WAIT: begin
                if (iresp.data_ok) state_d = FQ_IDLE;
            end
            default: state_d = FQ_IDLE;
        endcase
        if (resolve) stale_d = 1'b0;
        // Only a transaction still outstanding after this edge can return a stale word.
        if (miss) begin
            nxt_addr_d = creq.addr;
            if (busy && !resolve) stale_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= FQ_IDLE;
            stale_q    <= 1'b0;
            armed_q    <= 1'b0;
            nxt_addr_q <= '0;
            inflight_q <= '0;
        end else begin
            state_q    <= state_d;
            stale_q    <= stale_d;
            armed_q    <= armed_d;
            nxt_addr_q <= nxt_addr_d;
            inflight_q <= inflight_d;
        end
    end

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: scoreboard of expected core words, ibus responder model,
// and a monitor that checks every cresp beat. Honours IFETCH_QUEUE_BYPASS_EN for timing checks.
module tb_ifetch_queue;
    import ifetch_queue_pkg::*;

    logic       clk;
    logic       reset;
    ibus_req_t  creq;
    ibus_resp_t cresp;
    ibus_req_t  ireq;
    ibus_resp_t iresp;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc   = 0;
    logic [31:0] exp_q[$];
    logic [63:0] log_q[$];

    bit          mode_same;
    bit          hold;
    logic [63:0] hold_addr;
    bit          pend;
    logic [63:0] pend_addr;
    int          dok_cyc;

    localparam logic [63:0] A0 = 64'h0000_0000_8000_0000;

    ifetch_queue #(
        .DEPTH (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .creq  (creq),
        .cresp (cresp),
        .ireq  (ireq),
        .iresp (iresp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    function automatic logic [31:0] memw(input logic [63:0] a);
        return (a[31:0] * 32'd2654435761) ^ 32'h5A5A_C3C3;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ibus responder: decides the response for the coming edge at each falling edge.
    initial begin
        iresp = '0;
        pend  = 1'b0;
        forever begin
            @(negedge clk);
            iresp = '0;
            if (reset) begin
                pend = 1'b0;
            end else if (pend) begin
                if (!(hold && pend_addr == hold_addr)) begin
                    iresp.data_ok = 1'b1;
                    iresp.data    = memw(pend_addr);
                    pend          = 1'b0;
                    if (pend_addr == A0 + 64'h2000) dok_cyc = cyc;
                end
            end else if (ireq.valid) begin
                iresp.addr_ok = 1'b1;
                log_q.push_back(ireq.addr);
                if (mode_same) begin
                    iresp.data_ok = 1'b1;
                    iresp.data    = memw(ireq.addr);
                    if (ireq.addr == A0 + 64'h2000) dok_cyc = cyc;
                end else begin
                    pend      = 1'b1;
                    pend_addr = ireq.addr;
                end
            end
        end
    end

    // Monitor: every delivered word must be the next one the core asked for.
    initial forever begin
        @(negedge clk);
        #2;
        if (!reset) begin
            if (cresp.data_ok) begin
                check("cresp_addr_ok", 64'(cresp.addr_ok), 64'd1);
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_data_ok: got data %h expected no response (cycle %0d)",
                             cresp.data, cyc);
                end else begin
                    check("cresp_data", 64'(cresp.data), 64'(exp_q.pop_front()));
                end
            end else begin
                check("cresp_data_zero", 64'(cresp.data), 64'd0);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic fetch_start(input logic [63:0] a, input bit expect_word);
        if (expect_word) exp_q.push_back(memw(a));
        creq.valid = 1'b1;
        creq.addr  = a;
    endtask

    task automatic fetch_wait(output int lat, output int done_cyc);
        bit done = 1'b0;
        lat = 0;
        done_cyc = -1;
        while (!done) begin
            @(negedge clk);
            #2;
            if (cresp.data_ok) begin
                done     = 1'b1;
                done_cyc = cyc;
            end else begin
                lat++;
                if (lat > 200) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL fetch_timeout: got no data_ok for %h expected one within 200 cycles",
                             creq.addr);
                    done = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        creq = '0;
    endtask

    task automatic fetch(input logic [63:0] a, output int lat);
        int dc;
        fetch_start(a, 1'b1);
        fetch_wait(lat, dc);
    endtask

    initial begin
        int lat;
        int dc;
        reset     = 1'b1;
        creq      = '0;
        mode_same = 1'b0;
        hold      = 1'b0;
        hold_addr = '0;
        dok_cyc   = -1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2;
        check("reset_ireq", 64'(ireq), 64'd0);
        check("reset_cresp", 64'(cresp), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (5) begin
            @(negedge clk);
            #2;
            check("unarmed_no_ireq", 64'(ireq.valid), 64'd0);
        end

        // 1: arm with a single-cycle request, then the queue fills to DEPTH and stops
        @(posedge clk);
        #1;
        log_q.delete();
        fetch_start(A0, 1'b0);
        @(negedge clk);
        #2;
        check("t1_first_is_miss", 64'(cresp.data_ok), 64'd0);
        @(posedge clk);
        #1;
        creq = '0;
        idle(20);
        @(negedge clk);
        #2;
        check("t1_prefetch_count", 64'(log_q.size()), 64'd4);
        for (int i = 0; i < 4 && i < log_q.size(); i++)
            check("t1_prefetch_addr", log_q[i], A0 + 64'(4 * i));
        check("t1_full_no_ireq", 64'(ireq.valid), 64'd0);
        idle(1);

        // 2: hit on the head in the same cycle, then refill continues at +0x10
        log_q.delete();
        fetch(A0, lat);
        check("t2_hit_latency", 64'(lat), 64'd0);
        idle(20);
        check("t2_refill_addr", (log_q.size() > 0) ? log_q[0] : '1, A0 + 64'h10);

        // 3: flush while a prefetch is stuck in WAIT; its word must be dropped
        hold_addr = A0 + 64'h20;
        hold      = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            fetch(A0 + 64'(4 * i), lat);
            check("t3_hit_latency", 64'(lat), 64'd0);
        end
        idle(20);
        log_q.delete();
        fetch_start(A0 + 64'h100, 1'b1);
        idle(5);
        hold = 1'b0;
        fetch_wait(lat, dc);
        check("t3_refetch_addr", (log_q.size() > 0) ? log_q[0] : '1, A0 + 64'h100);

        // 4: addr_ok and data_ok together; addresses issued strictly sequentially
        idle(20);
        mode_same = 1'b1;
        log_q.delete();
        for (int i = 0; i < 8; i++) fetch(A0 + 64'h1000 + 64'(4 * i), lat);
        idle(5);
        for (int i = 0; i < 8; i++)
            check("t4_seq_addr", (i < log_q.size()) ? log_q[i] : '1, A0 + 64'h1000 + 64'(4 * i));

        // 5: miss latency relative to the bus data_ok cycle
        idle(20);
        mode_same = 1'b0;
        dok_cyc   = -1;
        fetch_start(A0 + 64'h2000, 1'b1);
        fetch_wait(lat, dc);
`ifdef IFETCH_QUEUE_BYPASS_EN
        check("t5_miss_timing", 64'(dc - dok_cyc), 64'd0);
`else
        check("t5_miss_timing", 64'(dc - dok_cyc), 64'd1);
`endif

        // 6: reset while the ibus transaction sits in WAIT
        idle(20);
        hold_addr = A0 + 64'h3000;
        hold      = 1'b1;
        fetch_start(A0 + 64'h3000, 1'b0);
        idle(10);
        reset = 1'b1;
        creq  = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        hold  = 1'b0;
        log_q.delete();
        @(negedge clk);
        #2;
        check("t6_ireq_after_reset", 64'(ireq.valid), 64'd0);
        check("t6_cresp_after_reset", 64'(cresp), 64'd0);
        repeat (10) begin
            @(negedge clk);
            #2;
            check("t6_unarmed_no_ireq", 64'(ireq.valid), 64'd0);
        end
        idle(1);
        fetch(A0 + 64'h4000, lat);
        check("t6_first_addr", (log_q.size() > 0) ? log_q[0] : '1, A0 + 64'h4000);

        idle(5);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
